// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED index sequencer.
package led_seq_pkg;

    localparam int unsigned IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_MAX = IDX_W'(7);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One position up or down, wrapping modulo 8.
    function automatic idx_t idx_step(input idx_t cur, input logic down);
        return down ? (cur - IDX_W'(1)) : (cur + IDX_W'(1));
    endfunction

endpackage

// File: rtl/led_index_seq_if.sv
// Button/level inputs and LED index outputs of the sequencer.
interface led_index_seq_if;
    import led_seq_pkg::*;

    logic       run_btn;
    logic       step_btn;
    logic       dir;
    logic       bounce;
    idx_t       idx;
    logic       running;
    logic       tick;

    modport master (
        output run_btn, step_btn, dir, bounce,
        input  idx, running, tick
    );

    modport slave (
        input  run_btn, step_btn, dir, bounce,
        output idx, running, tick
    );

endinterface

// File: rtl/btn_debounce.sv
// Raw push button -> 2-flop sync -> stability counter -> registered rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEB = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CNT_W = (DEB > 1) ? $clog2(DEB) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_diff;
    logic w_done;

    assign w_diff = r_sync2 ^ r_level;
    assign w_done = (r_cnt == CNT_W'(DEB - 1));

    // Level follows the synchronized input only after DEB consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/led_index_seq.sv
// LED position sequencer: debounced run/step buttons, prescaled auto-step,
// wrap-around or ping-pong index feeding the 3-to-8 LED decoder.
module led_index_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV = 12_000_000,
    parameter int unsigned DEB = 50_000
) (
    input  logic            clk,
    input  logic            rst_n,
    led_index_seq_if.slave  bus
);

    localparam int unsigned PRE_W = $clog2(DIV);

    logic w_run_press;
    logic w_step_press;
    logic w_run_level;
    logic w_step_level;
    logic w_unused_levels;

    btn_debounce #(.DEB(DEB)) u_run_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.run_btn),
        .level (w_run_level),
        .press (w_run_press)
    );

    btn_debounce #(.DEB(DEB)) u_step_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (bus.step_btn),
        .level (w_step_level),
        .press (w_step_press)
    );

    assign w_unused_levels = w_run_level ^ w_step_level;

    state_t           r_state;
    logic [PRE_W-1:0] r_pre;
    idx_t             r_idx;
    logic             r_bdir;
    logic             r_running;
    logic             r_tick;
    logic             r_dir_s1;
    logic             r_dir_s2;
    logic             r_bnc_s1;
    logic             r_bnc_s2;
    logic             r_bnc_q;

    state_t           w_state_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    idx_t             w_idx_nxt;
    idx_t             w_idx_step;
    logic             w_bdir_nxt;
    logic             w_bdir_eff;
    logic             w_bnc_rise;
    logic             w_down;
    logic             w_wrap;
    logic             w_adv;

    // Next state, prescaler and advance decision; a run press always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_adv       = 1'b0;
        w_wrap      = (r_pre == PRE_W'(DIV - 1));
        case (r_state)
            STOP: begin
                if (w_run_press) begin
                    w_state_nxt = RUN;
                    w_pre_nxt   = '0;
                end else if (w_step_press) begin
                    w_adv = 1'b1;
                end
            end
            RUN: begin
                if (w_run_press) begin
                    w_state_nxt = STOP;
                end else begin
                    w_pre_nxt = w_wrap ? '0 : (r_pre + PRE_W'(1));
                    w_adv     = w_wrap;
                end
            end
        endcase
    end

    // Direction select; in ping-pong mode the ends force the turn-around.
    always_comb begin
        w_bnc_rise = r_bnc_s2 & ~r_bnc_q;
        w_bdir_eff = w_bnc_rise ? r_dir_s2 : r_bdir;
        if (r_bnc_s2) begin
            w_down = (r_idx == IDX_MAX) | (w_bdir_eff & (r_idx != '0));
        end else begin
            w_down = r_dir_s2;
        end
        w_idx_step = idx_step(r_idx, w_down);
        w_idx_nxt  = w_adv ? w_idx_step : r_idx;
        w_bdir_nxt = w_bdir_eff;
        if (w_adv && r_bnc_s2) begin
            if (w_idx_step == IDX_MAX) begin
                w_bdir_nxt = 1'b1;
            end else if (w_idx_step == '0) begin
                w_bdir_nxt = 1'b0;
            end else begin
                w_bdir_nxt = w_down;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= STOP;
            r_pre     <= '0;
            r_idx     <= '0;
            r_bdir    <= 1'b0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_dir_s1  <= 1'b0;
            r_dir_s2  <= 1'b0;
            r_bnc_s1  <= 1'b0;
            r_bnc_s2  <= 1'b0;
            r_bnc_q   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_idx     <= w_idx_nxt;
            r_bdir    <= w_bdir_nxt;
            r_running <= (w_state_nxt == RUN);
            r_tick    <= w_adv;
            r_dir_s1  <= bus.dir;
            r_dir_s2  <= r_dir_s1;
            r_bnc_s1  <= bus.bounce;
            r_bnc_s2  <= r_bnc_s1;
            r_bnc_q   <= r_bnc_s2;
        end
    end

    assign bus.idx     = r_idx;
    assign bus.running = r_running;
    assign bus.tick    = r_tick;

endmodule

// File: tb/tb_led_index_seq.sv
// Scoreboard bench for led_index_seq with DIV=4, DEB=3.
module tb_led_index_seq;
    import led_seq_pkg::*;

    localparam int unsigned DIV = 4;
    localparam int unsigned DEB = 3;
    // Raw button edge to visible effect: 2 sync + DEB + 1 edge detect + 1 update.
    localparam int LAT = 2 + DEB + 1 + 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_index_seq_if bus();

    led_index_seq #(.DIV(DIV), .DEB(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int idx;
        int run;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void push_exp(input int c, input int i, input int r);
        exp_t e;
        e.cyc = c;
        e.idx = i;
        e.run = r;
        exp_q.push_back(e);
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic step_press(input int exp_idx);
        @(negedge clk);
        push_exp(cyc + LAT, exp_idx, 0);
        bus.step_btn = 1'b1;
        repeat (10) @(negedge clk);
        bus.step_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Every tick must match the next expected (cycle, idx, running).
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick_idx", int'(bus.idx), -1);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.cyc);
                chk("tick_idx", int'(bus.idx), e.idx);
                chk("tick_running", int'(bus.running), e.run);
            end
        end
    end

    int auto_seq [19] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 2, 1, 0, 7, 6, 5, 4, 3};
    int bnc_seq  [14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        int c0;
        int e;

        rst_n        = 1'b0;
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        bus.dir      = 1'b0;
        bus.bounce   = 1'b0;
        #1;
        chk("reset_idx", int'(bus.idx), 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_tick", int'(bus.tick), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_idx", int'(bus.idx), 0);

        // Bouncing step button never stable for DEB cycles, then a clean hold.
        for (int i = 0; i < 10; i++) begin
            bus.step_btn = ~bus.step_btn;
            repeat (2) @(negedge clk);
        end
        c0 = cyc;
        push_exp(c0 + LAT, 1, 0);
        bus.step_btn = 1'b1;
        repeat (10) @(negedge clk);
        bus.step_btn = 1'b0;
        repeat (10) @(negedge clk);
        chk("debounce_idx", int'(bus.idx), 1);

        bus.step_btn = 1'b1;
        repeat (2) @(negedge clk);
        bus.step_btn = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_idx", int'(bus.idx), 1);

        rst_n = 1'b0;
        #1;
        chk("reset2_idx", int'(bus.idx), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Auto run up, dir flip mid-run, then run press colliding with a wrap at idx 3.
        c0 = cyc;
        e  = c0 + LAT;
        bus.run_btn = 1'b1;
        for (int k = 1; k <= 19; k++) push_exp(e + 4 * k, auto_seq[k-1], 1);
        wait_until(e - 1);
        chk("pre_run_running", int'(bus.running), 0);
        wait_until(e);
        chk("run_entry_running", int'(bus.running), 1);
        wait_until(c0 + 10);
        bus.run_btn = 1'b0;
        wait_until(e + 45);
        bus.dir = 1'b1;
        wait_until(e + 73);
        bus.run_btn = 1'b1;
        wait_until(e + 79);
        chk("pre_collide_running", int'(bus.running), 1);
        chk("pre_collide_idx", int'(bus.idx), 3);
        wait_until(e + 80);
        chk("collide_running", int'(bus.running), 0);
        chk("collide_idx", int'(bus.idx), 3);
        chk("collide_tick", int'(bus.tick), 0);
        wait_until(e + 85);
        bus.run_btn = 1'b0;
        wait_until(e + 95);
        bus.dir = 1'b0;
        repeat (3) @(negedge clk);
        step_press(4);
        chk("post_collide_idx", int'(bus.idx), 4);

        // Ping-pong from 0 by single steps.
        rst_n = 1'b0;
        #1;
        chk("reset3_idx", int'(bus.idx), 0);
        bus.bounce = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 14; k++) step_press(bnc_seq[k]);
        chk("bounce_end_idx", int'(bus.idx), 0);

        // Run and step pressed together: run only, then reset at idx 5 mid-count.
        @(negedge clk);
        c0 = cyc;
        e  = c0 + LAT;
        bus.run_btn  = 1'b1;
        bus.step_btn = 1'b1;
        for (int k = 1; k <= 5; k++) push_exp(e + 4 * k, k, 1);
        wait_until(e);
        chk("both_running", int'(bus.running), 1);
        chk("both_idx", int'(bus.idx), 0);
        wait_until(c0 + 10);
        bus.run_btn  = 1'b0;
        bus.step_btn = 1'b0;
        wait_until(e + 22);
        chk("mid_idx", int'(bus.idx), 5);
        chk("mid_running", int'(bus.running), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_idx", int'(bus.idx), 0);
        chk("async_rst_running", int'(bus.running), 0);
        chk("async_rst_tick", int'(bus.tick), 0);
        wait_until(e + 25);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idx", int'(bus.idx), 0);
        chk("post_rst_running", int'(bus.running), 0);
        chk("pending_ticks", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
